// File: rtl/pb_debounce.sv
// pb_debounce: pushbutton / switch conditioner.
//   Synchronizes a raw button level through two flops, then qualifies it with
//   a four-state FSM. A new level is accepted only after it holds for the
//   programmed interval. The block then presents the clean level plus
//   one-cycle press and release strobes.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   pb_in      raw asynchronous button level, 1 = pressed
//   pb_level   debounced button level (registered)
//   pb_pulse   one-cycle strobe on each accepted press (registered)
//   pb_release one-cycle strobe on each accepted release (registered)
module pb_debounce #(
    parameter int unsigned          CNT_W   = 20,
    parameter logic [CNT_W-1:0]     CNT_MAX = 20'd999_999
) (
    input  logic clk,
    input  logic reset,
    input  logic pb_in,
    output logic pb_level,
    output logic pb_pulse,
    output logic pb_release
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    logic [1:0]       sync_q, sync_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             release_q, release_d;
    logic             pb_s;

    assign pb_s = sync_q[1];

    always_comb begin
        sync_d = {sync_q[0], pb_in};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pb_s) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!pb_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!pb_s) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (pb_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Level is registered from the next state so it moves on the same
        // edge as the state entering PRESSED or IDLE.
        level_d = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
        end
    end

    assign pb_level   = level_q;
    assign pb_pulse   = pulse_q;
    assign pb_release = release_q;

endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce: a small-interval instance (CNT_MAX=4) driven by
// table segments, hand sequences and random stimulus against a run-length
// reference model, plus a wider instance (CNT_MAX=1023, all-ones counter)
// for latency at the counter's top value.
module tb_pb_debounce;

    localparam int unsigned SMALL_MAX = 4;
    localparam int unsigned SMALL_LAT = SMALL_MAX + 4;
    localparam int unsigned BIG_MAX   = 1023;
    localparam int unsigned BIG_LAT   = BIG_MAX + 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pb_in = 1'b0;
    logic pb_level, pb_pulse, pb_release;
    logic pb_in2 = 1'b0;
    logic pb_level2, pb_pulse2, pb_release2;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    pb_debounce #(.CNT_W(3), .CNT_MAX(3'd4)) u_dut (
        .clk(clk), .reset(reset), .pb_in(pb_in),
        .pb_level(pb_level), .pb_pulse(pb_pulse), .pb_release(pb_release)
    );

    pb_debounce #(.CNT_W(10), .CNT_MAX(10'd1023)) u_big (
        .clk(clk), .reset(reset), .pb_in(pb_in2),
        .pb_level(pb_level2), .pb_pulse(pb_pulse2), .pb_release(pb_release2)
    );

    // Reference: the input is seen two edges late; the output level flips once
    // the seen input has disagreed with it for CNT_MAX+2 consecutive edges.
    typedef struct {
        logic        s1, s2, lvl, pulse, rel;
        int unsigned run;
    } model_t;

    model_t mdl = '{default: 0};

    function automatic model_t model_step(model_t m, logic in);
        model_t n = m;
        n.pulse = 1'b0;
        n.rel   = 1'b0;
        if (m.s2 != m.lvl) begin
            n.run = m.run + 1;
            if (n.run == SMALL_MAX + 2) begin
                n.lvl   = ~m.lvl;
                n.pulse = n.lvl;
                n.rel   = ~n.lvl;
                n.run   = 0;
            end
        end else begin
            n.run = 0;
        end
        n.s2 = m.s1;
        n.s1 = in;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) mdl <= '{default: 0};
        else        mdl <= model_step(mdl, pb_in);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // From a negedge with reset just released and pb_in held at 1.
    task automatic run_press_check(input string name);
        for (int k = 1; k <= SMALL_LAT + 2; k++) begin
            @(posedge clk); @(negedge clk);
            check({name, "_pulse"},   pb_pulse,   (k == SMALL_LAT) ? 1 : 0);
            check({name, "_level"},   pb_level,   (k >= SMALL_LAT) ? 1 : 0);
            check({name, "_release"}, pb_release, 0);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        pb;
        int unsigned cycles;
        logic        exp_level;
        int unsigned exp_pulses;
        int unsigned exp_rels;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned both;
        int unsigned lat;
        int unsigned run_left;
        logic        v;

        vecs[0]  = '{1'b1, 1'b1, 3,  1'b0, 0, 0};  // bounce: 3 high
        vecs[1]  = '{1'b1, 1'b0, 2,  1'b0, 0, 0};  //         2 low
        vecs[2]  = '{1'b1, 1'b1, 3,  1'b0, 0, 0};  //         3 high
        vecs[3]  = '{1'b1, 1'b0, 10, 1'b0, 0, 0};
        vecs[4]  = '{1'b1, 1'b1, 50, 1'b1, 1, 0};  // long hold: one pulse
        vecs[5]  = '{1'b1, 1'b0, 2,  1'b1, 0, 0};  // release bounce
        vecs[6]  = '{1'b1, 1'b1, 2,  1'b1, 0, 0};
        vecs[7]  = '{1'b1, 1'b0, 20, 1'b0, 0, 1};
        vecs[8]  = '{1'b1, 1'b1, 5,  1'b0, 0, 0};  // CNT_MAX+1 glitch
        vecs[9]  = '{1'b1, 1'b0, 10, 1'b0, 0, 0};
        vecs[10] = '{1'b1, 1'b1, 6,  1'b0, 0, 0};  // exactly CNT_MAX+2
        vecs[11] = '{1'b1, 1'b0, 12, 1'b0, 1, 1};
        vecs[12] = '{1'b1, 1'b1, 7,  1'b0, 0, 0};  // mid-count then reset
        vecs[13] = '{1'b0, 1'b1, 2,  1'b0, 0, 0};
        vecs[14] = '{1'b1, 1'b1, 8,  1'b1, 1, 0};
        vecs[15] = '{1'b1, 1'b0, 8,  1'b0, 0, 1};

        // Reset held with button pressed
        reset = 1'b0;
        pb_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_level",   pb_level,   0);
        check("rst_pulse",   pb_pulse,   0);
        check("rst_release", pb_release, 0);

        reset = 1'b1;
        run_press_check("t1");

        // Asynchronous reset while PRESSED
        #2 reset = 1'b0;
        #1 check("rst_pressed_level", pb_level, 0);
        @(negedge clk) reset = 1'b1;

        // Asynchronous reset mid-WAIT_PRESS (counter at 2), then fresh press
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1 check("rst_midcount_level", pb_level, 0);
        check("rst_midcount_pulse", pb_pulse, 0);
        @(negedge clk) reset = 1'b1;
        run_press_check("t5");

        // Asynchronous reset during the pulse cycle itself
        #2 reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        for (int k = 1; k <= SMALL_LAT; k++) begin
            @(posedge clk); @(negedge clk);
        end
        check("pulse_before_rst", pb_pulse, 1);
        #2 reset = 1'b0;
        #1 check("rst_in_pulse_pulse", pb_pulse, 0);
        check("rst_in_pulse_level", pb_level, 0);
        @(negedge clk) pb_in = 1'b0;
        @(negedge clk) reset = 1'b1;

        // Table segments
        both = 0;
        for (int i = 0; i < 16; i++) begin
            int unsigned p;
            int unsigned r;
            p = 0;
            r = 0;
            reset = vecs[i].rst_n;
            pb_in = vecs[i].pb;
            for (int unsigned c = 0; c < vecs[i].cycles; c++) begin
                @(posedge clk); @(negedge clk);
                if (pb_pulse) p++;
                if (pb_release) r++;
                if (pb_pulse && pb_release) both++;
            end
            check($sformatf("vec%0d_level", i),    pb_level, vecs[i].exp_level);
            check($sformatf("vec%0d_pulses", i),   p,        vecs[i].exp_pulses);
            check($sformatf("vec%0d_releases", i), r,        vecs[i].exp_rels);
        end
        check("vec_pulse_and_release_same_cycle", both, 0);

        // Wide instance: latency with counter reaching all-ones
        pb_in2 = 1'b1;
        lat = 0;
        for (int k = 1; k <= BIG_LAT + 100; k++) begin
            @(posedge clk); @(negedge clk);
            if (pb_pulse2) begin lat = k; break; end
        end
        check("big_press_latency", lat, BIG_LAT);
        check("big_level_at_pulse", pb_level2, 1);
        @(posedge clk); @(negedge clk);
        check("big_pulse_one_cycle", pb_pulse2, 0);
        pb_in2 = 1'b0;
        lat = 0;
        for (int k = 1; k <= BIG_LAT + 100; k++) begin
            @(posedge clk); @(negedge clk);
            if (pb_release2) begin lat = k; break; end
        end
        check("big_release_latency", lat, BIG_LAT);
        check("big_level_after_release", pb_level2, 0);

        // Random stimulus against the reference model
        run_left = 0;
        v = pb_in;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                v = ~v;
                run_left = $urandom_range(1, 12);
            end
            run_left--;
            pb_in = v;
            reset = ($urandom_range(0, 199) != 0);
            @(posedge clk); @(negedge clk);
            check("rnd_level",   pb_level,   mdl.lvl);
            check("rnd_pulse",   pb_pulse,   mdl.pulse);
            check("rnd_release", pb_release, mdl.rel);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
